gol_controller: RTL and testbench

Generation sequencer for the Game of Life datapath (`gol`). It accepts user commands (load seed, single-step, run, stop) and paces free-running evolution with a programmable prescaler. It issues one-cycle load/advance strobes to the datapath and waits for the datapath's completion pulse between generations. It also maintains a generation counter for the display path.

---
 rtl/gol_pkg.sv | 19 +
 rtl/gol_controller_if.sv | 13 +
 rtl/gol_prescaler.sv | 34 +++
 rtl/gol_controller.sv | 135 +++++++++++++
 tb/tb_gol_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gol_pkg.sv
// Shared types for the Game of Life datapath, its controller and the display path.
package gol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WAIT,
        STEP_WAIT,
        RUN,
        RUN_WAIT
    } gol_ctrl_state_t;

    typedef logic [1:0] seed_idx_t;

    localparam seed_idx_t SEED_GLIDER  = 2'd0;
    localparam seed_idx_t SEED_BLINKER = 2'd1;
    localparam seed_idx_t SEED_RPENT   = 2'd2;
    localparam seed_idx_t SEED_RANDOM  = 2'd3;

endpackage

// File: rtl/gol_controller_if.sv
// Strobe/completion handshake between the generation sequencer and the gol datapath.
interface gol_controller_if;
    import gol_pkg::*;

    logic      dp_load;
    logic      dp_adv;
    seed_idx_t seed_q;
    logic      dp_done;

    modport master (output dp_load, output dp_adv, output seed_q, input dp_done);
    modport slave  (input dp_load, input dp_adv, input seed_q, output dp_done);

endinterface

// File: rtl/gol_prescaler.sv
// Free-running generation pacer; tc compares against the live rate_div so rate changes apply at once.
module gol_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tc
);

    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q >= rate_div);

endmodule

// File: rtl/gol_controller.sv
// Generation sequencer: turns user commands into load/advance strobes and counts completed generations.
module gol_controller
    import gol_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              load,
    input  seed_idx_t         seed_sel,
    input  logic [DIV_W-1:0]  rate_div,
    gol_controller_if.master  dp,
    output logic [GEN_W-1:0]  gen_count,
    output logic              running,
    output logic              busy
);

    gol_ctrl_state_t  state_q, state_d;
    seed_idx_t        seed_q, seed_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic             dp_load_q, dp_load_d;
    logic             dp_adv_q, dp_adv_d;
    logic             stop_pend_q, stop_pend_d;
    logic             running_q, running_d;
    logic             busy_q, busy_d;
    logic             pre_clr, pre_en, pre_tc;
    logic             done_ok;

    gol_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr      (pre_clr),
        .en       (pre_en),
        .rate_div (rate_div),
        .tc       (pre_tc)
    );

    // A completion coincident with our own strobe cannot belong to that operation.
    assign done_ok = dp.dp_done && !dp_load_q && !dp_adv_q;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        gen_count_d = gen_count_q;
        dp_load_d   = 1'b0;
        dp_adv_d    = 1'b0;
        stop_pend_d = stop_pend_q;
        pre_clr     = 1'b0;
        pre_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    seed_d      = seed_sel;
                    dp_load_d   = 1'b1;
                    gen_count_d = '0;
                    state_d     = LOAD_WAIT;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    pre_clr = 1'b1;
                    state_d = RUN;
                end else if (step) begin
                    dp_adv_d = 1'b1;
                    state_d  = STEP_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (done_ok) state_d = IDLE;
            end
            STEP_WAIT: begin
                if (done_ok) begin
                    gen_count_d = gen_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pre_tc) begin
                    pre_clr  = 1'b1;
                    dp_adv_d = 1'b1;
                    state_d  = RUN_WAIT;
                end else begin
                    pre_en = 1'b1;
                end
            end
            RUN_WAIT: begin
                if (done_ok) begin
                    gen_count_d = gen_count_q + 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = (stop_pend_q || stop) ? IDLE : RUN;
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN) || (state_d == RUN_WAIT);
        busy_d    = (state_d == LOAD_WAIT) || (state_d == STEP_WAIT) || (state_d == RUN_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            gen_count_q <= '0;
            dp_load_q   <= 1'b0;
            dp_adv_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            running_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            gen_count_q <= gen_count_d;
            dp_load_q   <= dp_load_d;
            dp_adv_q    <= dp_adv_d;
            stop_pend_q <= stop_pend_d;
            running_q   <= running_d;
            busy_q      <= busy_d;
        end
    end

    assign dp.dp_load = dp_load_q;
    assign dp.dp_adv  = dp_adv_q;
    assign dp.seed_q  = seed_q;
    assign gen_count  = gen_count_q;
    assign running    = running_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gol_controller.sv
// Bench for gol_controller: vector table for load/step transactions, scripted sequences for RUN, stop, priority and reset.
module tb_gol_controller;
    import gol_pkg::*;

    localparam int DIV_W = 24;
    localparam int GEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             step = 1'b0;
    logic             load = 1'b0;
    seed_idx_t        seed_sel = '0;
    logic [DIV_W-1:0] rate_div = 24'd4;
    logic [GEN_W-1:0] gen_count;
    logic             running;
    logic             busy;

    gol_controller_if dp_if ();

    gol_controller #(.DIV_W(DIV_W), .GEN_W(GEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .load      (load),
        .seed_sel  (seed_sel),
        .rate_div  (rate_div),
        .dp        (dp_if),
        .gen_count (gen_count),
        .running   (running),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        is_load;
        seed_idx_t seed;
        int        latency;
        int        exp_gen;
        int        exp_seed;
    } vec_t;

    typedef struct {
        int gen;
        int seed;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int adv_cnt = 0;
    int load_cnt = 0;

    // Strobe tally, used to prove that ignored commands issue nothing.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_if.dp_adv) adv_cnt <= adv_cnt + 1;
        if (dp_if.dp_load) load_cnt <= load_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        if (v.is_load) begin
            load     = 1'b1;
            seed_sel = v.seed;
        end else begin
            step = 1'b1;
        end
        e.gen  = v.exp_gen;
        e.seed = v.exp_seed;
        sb.push_back(e);
        tick();
        load     = 1'b0;
        step     = 1'b0;
        seed_sel = v.seed ^ 2'b11;
    endtask

    task automatic waitStrobe(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (dp_if.dp_load || dp_if.dp_adv) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic finishDp(input int latency);
        repeat (latency) tick();
        dp_if.dp_done = 1'b1;
        tick();
        dp_if.dp_done = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_dp_load"}, dp_if.dp_load, 0);
        checkOutput({tag, "_dp_adv"}, dp_if.dp_adv, 0);
        checkOutput({tag, "_seed_q"}, dp_if.seed_q, 0);
        checkOutput({tag, "_gen_count"}, gen_count, 0);
        checkOutput({tag, "_running"}, running, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit   ok;
        exp_t e;
        int   last_t;
        int   a0;
        int   l0;

        dp_if.dp_done = 1'b0;

        vecs[0] = '{1'b1, SEED_RPENT,   2, 0, 2};
        vecs[1] = '{1'b0, SEED_GLIDER,  3, 1, 2};
        vecs[2] = '{1'b0, SEED_GLIDER,  3, 2, 2};
        vecs[3] = '{1'b0, SEED_GLIDER,  3, 3, 2};
        vecs[4] = '{1'b0, SEED_GLIDER,  3, 4, 2};
        vecs[5] = '{1'b0, SEED_GLIDER,  3, 5, 2};
        vecs[6] = '{1'b1, SEED_BLINKER, 1, 0, 1};
        vecs[7] = '{1'b0, SEED_GLIDER,  1, 1, 1};
        vecs[8] = '{1'b1, SEED_RANDOM,  4, 0, 3};
        vecs[9] = '{1'b1, SEED_GLIDER,  1, 0, 0};

        repeat (3) tick();
        checkIdleZero("reset");
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            waitStrobe(10, ok);
            checkOutput("strobe_seen", ok, 1);
            if (ok) begin
                checkOutput(vecs[i].is_load ? "dp_load_hi" : "dp_adv_hi",
                            vecs[i].is_load ? dp_if.dp_load : dp_if.dp_adv, 1);
                checkOutput("other_strobe_lo",
                            vecs[i].is_load ? dp_if.dp_adv : dp_if.dp_load, 0);
                checkOutput("busy_with_strobe", busy, 1);
                if (vecs[i].is_load) checkOutput("seed_during_load", dp_if.seed_q, vecs[i].seed);
                tick();
                checkOutput("single_pulse", dp_if.dp_load | dp_if.dp_adv, 0);
                checkOutput("busy_waiting", busy, 1);
                finishDp(vecs[i].latency - 1);
            end
            e = sb.pop_front();
            checkOutput("busy_after_done", busy, 0);
            checkOutput("gen_count", gen_count, e.gen);
            checkOutput("seed_q", dp_if.seed_q, e.seed);
        end

        // Free run: rate_div=4 with datapath latency 2 gives an 8-cycle period.
        rate_div = 24'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("running_rise", running, 1);
        last_t = 0;
        for (int g = 0; g < 10; g++) begin
            waitStrobe(40, ok);
            checkOutput("run_adv_seen", ok, 1);
            if (!ok) break;
            checkOutput("run_no_load", dp_if.dp_load, 0);
            if (g > 0) checkOutput("run_period", cyc - last_t, 8);
            last_t = cyc;
            finishDp(2);
        end
        checkOutput("gen_after_run", gen_count, 10);
        checkOutput("running_in_run", running, 1);

        // Stop one cycle after the strobe: the pending generation still completes.
        waitStrobe(40, ok);
        checkOutput("stop_adv_seen", ok, 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("running_while_pending", running, 1);
        dp_if.dp_done = 1'b1;
        tick();
        dp_if.dp_done = 1'b0;
        checkOutput("gen_after_stop", gen_count, 11);
        checkOutput("running_after_stop", running, 0);
        checkOutput("busy_after_stop", busy, 0);
        a0 = adv_cnt;
        repeat (20) tick();
        checkOutput("no_adv_after_stop", adv_cnt - a0, 0);

        // load and start together: load wins.
        load = 1'b1;
        start = 1'b1;
        seed_sel = SEED_RPENT;
        tick();
        load = 1'b0;
        start = 1'b0;
        seed_sel = SEED_GLIDER;
        checkOutput("prio_dp_load", dp_if.dp_load, 1);
        checkOutput("prio_dp_adv", dp_if.dp_adv, 0);
        checkOutput("prio_running", running, 0);
        checkOutput("prio_seed", dp_if.seed_q, 2);
        checkOutput("prio_gen_clear", gen_count, 0);
        finishDp(1);
        checkOutput("prio_busy_done", busy, 0);

        // load during RUN is ignored.
        rate_div = 24'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        l0 = load_cnt;
        load = 1'b1;
        seed_sel = SEED_BLINKER;
        tick();
        load = 1'b0;
        repeat (3) tick();
        checkOutput("run_load_ignored", load_cnt - l0, 0);
        checkOutput("run_seed_kept", dp_if.seed_q, 2);
        checkOutput("run_still_running", running, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_from_run", running, 0);

        // Stray completion in IDLE.
        dp_if.dp_done = 1'b1;
        tick();
        dp_if.dp_done = 1'b0;
        tick();
        checkOutput("stray_done_gen", gen_count, 0);
        checkOutput("stray_done_busy", busy, 0);

        // rate_div=0 fires on the first RUN cycle; then reset lands in RUN_WAIT.
        rate_div = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("rdiv0_first_run_cycle", dp_if.dp_adv, 0);
        tick();
        checkOutput("rdiv0_adv", dp_if.dp_adv, 1);
        tick();
        checkOutput("runwait_busy", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkIdleZero("midreset");
        dp_if.dp_done = 1'b1;
        tick();
        dp_if.dp_done = 1'b0;
        repeat (3) tick();
        checkOutput("late_done_gen", gen_count, 0);
        checkOutput("late_done_busy", busy, 0);
        checkOutput("late_done_running", running, 0);
        checkOutput("late_done_adv", dp_if.dp_adv, 0);

        // Completion coincident with the strobe must not be accepted.
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("same_cycle_adv", dp_if.dp_adv, 1);
        dp_if.dp_done = 1'b1;
        tick();
        dp_if.dp_done = 1'b0;
        checkOutput("same_cycle_done_ignored", busy, 1);
        finishDp(0);
        checkOutput("real_done_busy", busy, 0);
        checkOutput("real_done_gen", gen_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
